// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums plus the default width.
package alu_seq_pkg;

    localparam int ALU_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_NAND = 3'b011,
        OP_SUB  = 3'b100,
        OP_MUL  = 3'b101,
        OP_RSVD = 3'b110,
        OP_ADD2 = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle ADD/SUB/NAND datapath and illegal-opcode decode.
// ALU_SEQ_MUL_EN decides whether opcode 101 counts as supported.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_W_DEFAULT
) (
    input  alu_op_t        op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic           cin_i,
    output logic [W-1:0]   res_o,
    output logic           cout_o,
    output logic           illegal_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    // The W+1 bit difference wraps, so its top bit is the borrow flag.
    always_comb begin
        sum       = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
        diff      = {1'b0, a_i} - {1'b0, b_i} + {{W{1'b0}}, cin_i};
        res_o     = '0;
        cout_o    = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD, OP_ADD2: {cout_o, res_o} = sum;
            OP_SUB:          {cout_o, res_o} = diff;
            OP_NAND:         res_o = ~(a_i & b_i);
            OP_RSVD:         illegal_o = 1'b1;
`ifndef ALU_SEQ_MUL_EN
            OP_MUL:          illegal_o = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: IDLE/BUSY/DONE handshake FSM, bit-serial shifter and,
// when ALU_SEQ_MUL_EN is defined, a shift-add multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W  = ALU_W_DEFAULT,
    parameter int SW = $clog2(W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     alu_cmd,
    input  logic [W-1:0]   inA,
    input  logic [W-1:0]   inB,
    input  logic           sc_i,
    input  logic [SW-1:0]  shamt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   rslt,
    output logic           sc_o,
    output logic           zero,
    output logic           pari,
    output logic           illegal
);

    // One extra counter bit so a full W-step multiply count fits.
    localparam int CW = SW + 1;

    alu_state_t     state_q, state_d;
    alu_op_t        op_q, op_d, cmd;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           sc_q, sc_d;
    logic           illegal_q, illegal_d;
    logic           fill_q, fill_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           accept;
    logic [W-1:0]   coreRes;
    logic           coreCout, coreIllegal;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W:0]     partial;
`endif

    assign cmd    = alu_op_t'(alu_cmd);
    assign accept = in_valid && (state_q == IDLE);

    alu_seq_core #(.W(W)) u_core (
        .op_i      (cmd),
        .a_i       (inA),
        .b_i       (inB),
        .cin_i     (sc_i),
        .res_o     (coreRes),
        .cout_o    (coreCout),
        .illegal_o (coreIllegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (cmd)
                        OP_SHL, OP_SHR: state_d = (shamt == '0) ? DONE : BUSY;
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL:         state_d = BUSY;
`endif
                        default:        state_d = DONE;
                    endcase
                end
            end
            BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Multi-cycle ops reuse rslt_q as the working register (shift value or multiplier/low product).
    always_comb begin
        op_d      = op_q;
        rslt_d    = rslt_q;
        sc_d      = sc_q;
        illegal_d = illegal_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        partial   = '0;
`endif
        if (accept) begin
            op_d      = cmd;
            fill_d    = sc_i;
            rslt_d    = coreRes;
            sc_d      = coreCout;
            illegal_d = coreIllegal;
            cnt_d     = '0;
            if (cmd == OP_SHL || cmd == OP_SHR) begin
                rslt_d = inA;
                sc_d   = 1'b0;
                cnt_d  = {1'b0, shamt};
            end
`ifdef ALU_SEQ_MUL_EN
            if (cmd == OP_MUL) begin
                rslt_d  = inB;
                sc_d    = 1'b0;
                cnt_d   = CW'(W);
                mcand_d = inA;
                hi_d    = '0;
            end
`endif
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CW'(1);
            case (op_q)
                OP_SHL: begin
                    sc_d   = rslt_q[W-1];
                    rslt_d = {rslt_q[W-2:0], fill_q};
                end
                OP_SHR: begin
                    sc_d   = rslt_q[0];
                    rslt_d = {fill_q, rslt_q[W-1:1]};
                end
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    partial = {1'b0, hi_q} + (rslt_q[0] ? {1'b0, mcand_q} : '0);
                    hi_d    = partial[W:1];
                    rslt_d  = {partial[0], rslt_q[W-1:1]};
                    sc_d    = |partial[W:1];
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_ADD;
            rslt_q    <= '0;
            sc_q      <= 1'b0;
            illegal_q <= 1'b0;
            fill_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= '0;
            hi_q      <= '0;
`endif
        end else begin
            op_q      <= op_d;
            rslt_q    <= rslt_d;
            sc_q      <= sc_d;
            illegal_q <= illegal_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
`endif
        end
    end

    assign rslt    = rslt_q;
    assign sc_o    = sc_q;
    assign illegal = illegal_q;
    assign zero    = (rslt_q == '0);
    assign pari    = ^rslt_q;

endmodule
